// File: rtl/alarm_code_controller.sv
// Keypad code checker and arm / exit-delay / entry-delay / alarm / lockout sequencer.
// Define ALARM_AUTO_SILENCE_EN to return from ALARM to ARMED after ALARM_TIME cycles.
module alarm_code_controller #(
    parameter int NUM_BTN = 4,
    parameter int CODE_LEN = 4,
    parameter logic [CODE_LEN*$clog2(NUM_BTN)-1:0] CODE = 8'hE4,
    parameter int EXIT_DELAY = 50_000_000,
    parameter int ENTRY_DELAY = 50_000_000,
    parameter int KEY_TIMEOUT = 100_000_000,
    parameter int MAX_FAIL = 3,
    parameter int LOCKOUT_TIME = 200_000_000,
    parameter int ALARM_TIME = 500_000_000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_BTN-1:0]                btn_db,
    input  logic                              sensor,
    output logic [2:0]                        state,
    output logic                              armed,
    output logic                              pending,
    output logic                              alarm,
    output logic                              locked,
    output logic                              code_ok,
    output logic                              code_fail,
    output logic [$clog2(CODE_LEN+1)-1:0]     digit_cnt
);

    localparam int W   = $clog2(NUM_BTN);
    localparam int CW  = $clog2(CODE_LEN + 1);
    localparam int KTW = $clog2(KEY_TIMEOUT + 1);
    localparam int FW  = $clog2(MAX_FAIL + 1);
    localparam int MAX_EE   = (EXIT_DELAY > ENTRY_DELAY) ? EXIT_DELAY : ENTRY_DELAY;
    localparam int BASE_MAX = (MAX_EE > LOCKOUT_TIME) ? MAX_EE : LOCKOUT_TIME;
`ifdef ALARM_AUTO_SILENCE_EN
    localparam int DLY_MAX = (BASE_MAX > ALARM_TIME) ? BASE_MAX : ALARM_TIME;
`else
    localparam int DLY_MAX = BASE_MAX;
`endif
    localparam int TW = $clog2(DLY_MAX + 1);

    if (EXIT_DELAY < 1 || ENTRY_DELAY < 1 || LOCKOUT_TIME < 1 || KEY_TIMEOUT < 1 ||
        ALARM_TIME < 1 || MAX_FAIL < 1) begin : g_param_check
        $error("alarm_code_controller: all delays and MAX_FAIL must be at least 1");
    end

    typedef enum logic [2:0] {
        S_DISARMED  = 3'd0,
        S_EXIT_DLY  = 3'd1,
        S_ARMED     = 3'd2,
        S_ENTRY_DLY = 3'd3,
        S_ALARM     = 3'd4,
        S_LOCKOUT   = 3'd5
    } state_t;

    state_t             state_q, state_n;
    logic [NUM_BTN-1:0] btn_prev, rise;
    logic               multi, press;
    logic [W-1:0]       digit, exp_digit;
    logic               mismatch, mismatch_n;
    logic               last_digit, ok_ev, fail_ev, penalty;
    logic [KTW-1:0]     key_timer;
    logic               key_expired;
    logic [FW-1:0]      fail_cnt;
    logic [TW-1:0]      timer, timer_load;
    logic               armed_n, pending_n, alarm_n, locked_n;

    assign state = state_q;

    // Press decode and code evaluation; a multi-key press always counts as a wrong digit.
    always_comb begin : press_decode
        rise  = btn_db & ~btn_prev;
        multi = |(rise & (rise - NUM_BTN'(1)));
        press = (|rise) && (state_q != S_LOCKOUT);
        digit = '0;
        for (int unsigned i = 0; i < NUM_BTN; i++) begin
            if (rise[i]) digit = W'(i);
        end
        exp_digit = '0;
        for (int unsigned i = 0; i < CODE_LEN; i++) begin
            if (digit_cnt == CW'(i)) exp_digit = CODE[i*W +: W];
        end
        mismatch_n  = mismatch | multi | (digit != exp_digit);
        last_digit  = press && (digit_cnt == CW'(CODE_LEN - 1));
        ok_ev       = last_digit && !mismatch_n;
        fail_ev     = last_digit && mismatch_n;
        penalty     = fail_ev && (fail_cnt == FW'(MAX_FAIL - 1));
        key_expired = !press && (digit_cnt != '0) && (key_timer == '0);
    end

    always_comb begin : next_state_logic
        state_n = state_q;
        case (state_q)
            S_DISARMED: begin
                if (ok_ev)        state_n = S_EXIT_DLY;
                else if (penalty) state_n = S_LOCKOUT;
            end
            S_EXIT_DLY: begin
                if (ok_ev)              state_n = S_DISARMED;
                else if (penalty)       state_n = S_LOCKOUT;
                else if (timer == '0)   state_n = S_ARMED;
            end
            S_ARMED: begin
                if (ok_ev)        state_n = S_DISARMED;
                else if (penalty) state_n = S_ALARM;
                else if (sensor)  state_n = S_ENTRY_DLY;
            end
            S_ENTRY_DLY: begin
                if (ok_ev)              state_n = S_DISARMED;
                else if (penalty)       state_n = S_ALARM;
                else if (timer == '0)   state_n = S_ALARM;
            end
            S_ALARM: begin
                if (ok_ev) state_n = S_DISARMED;
`ifdef ALARM_AUTO_SILENCE_EN
                else if (!penalty && timer == '0) state_n = S_ARMED;
`endif
            end
            S_LOCKOUT: begin
                if (timer == '0) state_n = S_DISARMED;
            end
            default: state_n = S_DISARMED;
        endcase
    end

    always_comb begin : output_decode
        armed_n   = (state_n == S_ARMED) || (state_n == S_ENTRY_DLY) || (state_n == S_ALARM);
        pending_n = (state_n == S_EXIT_DLY) || (state_n == S_ENTRY_DLY);
        alarm_n   = (state_n == S_ALARM);
        locked_n  = (state_n == S_LOCKOUT);
        // Loaded with N-1 so the state is held for exactly N cycles before expiry.
        case (state_n)
            S_EXIT_DLY:  timer_load = TW'(EXIT_DELAY - 1);
            S_ENTRY_DLY: timer_load = TW'(ENTRY_DELAY - 1);
            S_LOCKOUT:   timer_load = TW'(LOCKOUT_TIME - 1);
`ifdef ALARM_AUTO_SILENCE_EN
            S_ALARM:     timer_load = TW'(ALARM_TIME - 1);
`endif
            default:     timer_load = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin : state_reg
        if (rst) begin
            state_q   <= S_DISARMED;
            armed     <= 1'b0;
            pending   <= 1'b0;
            alarm     <= 1'b0;
            locked    <= 1'b0;
            code_ok   <= 1'b0;
            code_fail <= 1'b0;
            timer     <= '0;
        end else begin
            state_q   <= state_n;
            armed     <= armed_n;
            pending   <= pending_n;
            alarm     <= alarm_n;
            locked    <= locked_n;
            code_ok   <= ok_ev;
            code_fail <= fail_ev;
            if (state_n != state_q)  timer <= timer_load;
            else if (timer != '0)    timer <= timer - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin : entry_reg
        if (rst) begin
            btn_prev  <= '0;
            digit_cnt <= '0;
            mismatch  <= 1'b0;
            key_timer <= '0;
            fail_cnt  <= '0;
        end else begin
            btn_prev <= btn_db;
            if (ok_ev || fail_ev || key_expired) begin
                digit_cnt <= '0;
                mismatch  <= 1'b0;
            end else if (press) begin
                digit_cnt <= digit_cnt + 1'b1;
                mismatch  <= mismatch_n;
            end
            if (press)                                      key_timer <= KTW'(KEY_TIMEOUT - 1);
            else if (digit_cnt != '0 && key_timer != '0)    key_timer <= key_timer - 1'b1;
            if (ok_ev)        fail_cnt <= '0;
            else if (fail_ev) fail_cnt <= penalty ? '0 : fail_cnt + 1'b1;
        end
    end

endmodule
